// File: rtl/c7bifu_issue_ctl.sv
// c7bifu_issue_ctl: issue sequencer that stalls decode/fetch while LSU, CSR and exception/ertn ops drain
//   clk, resetn               : clock, asynchronous active-low reset
//   inst_vld_d, dec_*_d       : ungated decode valid, class bits, rd and write enable
//   exu_stall, exu_lsu_done,
//   exu_lsu_exc, flush        : EXU stall request, LSU completion (+exception), pipeline flush
//   stall, issue_fire_d       : stall to decode/fetch, instruction accepted this cycle
//   ll_rd, ll_wb_vld          : rd of outstanding LSU op and its one-cycle writeback pulse
//   state_o, wdog_err         : debug state, sticky LSU watchdog timeout
module c7bifu_issue_ctl #(
  parameter int CSR_LAT = 2,
  parameter int WDOG_W  = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       inst_vld_d,
  input  logic       dec_lsu_d,
  input  logic       dec_csr_d,
  input  logic       dec_ertn_d,
  input  logic       dec_exc_d,
  input  logic [4:0] dec_rd_d,
  input  logic       dec_wen_d,
  input  logic       exu_stall,
  input  logic       exu_lsu_done,
  input  logic       exu_lsu_exc,
  input  logic       flush,
  output logic       stall,
  output logic       issue_fire_d,
  output logic [4:0] ll_rd,
  output logic       ll_wb_vld,
  output logic [2:0] state_o,
  output logic       wdog_err
);
  typedef enum logic [2:0] {IDLE, LSU_BUSY, LSU_KILL, CSR_BUSY, DRAIN} state_t;
  localparam int CW = CSR_LAT > 1 ? $clog2(CSR_LAT) : 1;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [WDOG_W-1:0] r_wdog;
  logic [4:0]        r_ll_rd;
  logic              r_wen_q;
  logic              r_wdog_err;
  logic              w_lsu_act;
  assign w_lsu_act    = (r_state == LSU_BUSY) || (r_state == LSU_KILL);
  // stall depends only on registered state, so the decoder's own op never stalls itself
  assign stall        = exu_stall | (r_state != IDLE);
  assign issue_fire_d = inst_vld_d & ~stall & ~flush;
  // a flush arriving with done still completes the op, so writeback only needs LSU_BUSY
  assign ll_wb_vld    = (r_state == LSU_BUSY) & exu_lsu_done & r_wen_q & ~exu_lsu_exc & (r_ll_rd != 5'd0);
  assign ll_rd        = r_ll_rd;
  assign state_o      = r_state;
  assign wdog_err     = r_wdog_err;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wdog     <= '0;
      r_ll_rd    <= '0;
      r_wen_q    <= 1'b0;
      r_wdog_err <= 1'b0;
    end else begin
      if (w_lsu_act && r_wdog != '1) r_wdog <= r_wdog + 1'b1;
      // sets as the counter steps onto all-ones (and stays set once there)
      if (w_lsu_act && r_wdog[WDOG_W-1:1] == '1) r_wdog_err <= 1'b1;
      case (r_state)
        IDLE:
          if (issue_fire_d) begin
            if (dec_exc_d || dec_ertn_d) r_state <= DRAIN;
            else if (dec_lsu_d) begin
              r_state <= LSU_BUSY;
              r_ll_rd <= dec_rd_d;
              r_wen_q <= dec_wen_d;
              r_wdog  <= '0;
            end else if (dec_csr_d) begin
              r_state <= CSR_BUSY;
              r_cnt   <= CW'(CSR_LAT - 1);
            end
          end
        LSU_BUSY: r_state <= exu_lsu_done ? IDLE : flush ? LSU_KILL : LSU_BUSY;
        LSU_KILL: r_state <= exu_lsu_done ? IDLE : LSU_KILL;
        CSR_BUSY: begin
          r_state <= (flush || r_cnt == '0) ? IDLE : CSR_BUSY;
          r_cnt   <= r_cnt - 1'b1;
        end
        DRAIN:    r_state <= flush ? IDLE : DRAIN;
        default:  r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c7bifu_issue_ctl.sv
module tb_c7bifu_issue_ctl;
  logic clk = 0, resetn = 0;
  logic vld = 0, lsu = 0, csr = 0, ertn = 0, exc = 0, wen = 0, est = 0, done = 0, lexc = 0, fl = 0;
  logic [4:0] rd = 0;
  logic a_stall, a_fire, a_wb, a_werr, b_stall, b_fire, b_wb, b_werr;
  logic [4:0] a_rd, b_rd;
  logic [2:0] a_st, b_st;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  c7bifu_issue_ctl dut_a (
    .clk(clk), .resetn(resetn), .inst_vld_d(vld), .dec_lsu_d(lsu), .dec_csr_d(csr),
    .dec_ertn_d(ertn), .dec_exc_d(exc), .dec_rd_d(rd), .dec_wen_d(wen), .exu_stall(est),
    .exu_lsu_done(done), .exu_lsu_exc(lexc), .flush(fl), .stall(a_stall),
    .issue_fire_d(a_fire), .ll_rd(a_rd), .ll_wb_vld(a_wb), .state_o(a_st), .wdog_err(a_werr));

  c7bifu_issue_ctl #(.CSR_LAT(1), .WDOG_W(4)) dut_b (
    .clk(clk), .resetn(resetn), .inst_vld_d(vld), .dec_lsu_d(lsu), .dec_csr_d(csr),
    .dec_ertn_d(ertn), .dec_exc_d(exc), .dec_rd_d(rd), .dec_wen_d(wen), .exu_stall(est),
    .exu_lsu_done(done), .exu_lsu_exc(lexc), .flush(fl), .stall(b_stall),
    .issue_fire_d(b_fire), .ll_rd(b_rd), .ll_wb_vld(b_wb), .state_o(b_st), .wdog_err(b_werr));

  typedef struct {
    logic vld, lsu, csr, ertn, exc;
    logic [4:0] rd;
    logic wen, est, done, lexc, fl;
    logic e_stall, e_fire, e_wb;
    logic [4:0] e_rd;
    logic [2:0] e_st;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t v(input logic i_vld, i_lsu, i_csr, i_ertn, i_exc, input logic [4:0] i_rd,
                             input logic i_wen, i_est, i_done, i_lexc, i_fl,
                             input logic x_stall, x_fire, x_wb, input logic [4:0] x_rd, input logic [2:0] x_st);
    vec_t r;
    r = '{i_vld, i_lsu, i_csr, i_ertn, i_exc, i_rd, i_wen, i_est, i_done, i_lexc, i_fl,
          x_stall, x_fire, x_wb, x_rd, x_st};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    {vld, lsu, csr, ertn, exc, wen, est, done, lexc, fl} = '0;
    rd = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    clr();
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    // vld lsu csr ertn exc rd wen est done lexc fl | stall fire wb ll_rd state
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 0,0));
    tv.push_back(v(1,0,0,0,0, 0,0,1,0,0,0, 1,0,0, 0,0));
    tv.push_back(v(1,0,0,0,0, 0,0,0,0,0,1, 0,0,0, 0,0));
    tv.push_back(v(0,0,0,0,0, 0,0,0,1,0,0, 0,0,0, 0,0));
    // LSU rd=5 fires at T, done at T+4
    tv.push_back(v(1,1,0,0,0, 5,1,0,0,0,0, 0,1,0, 0,0));
    tv.push_back(v(1,1,0,0,0, 5,1,0,0,0,0, 1,0,0, 5,1));
    tv.push_back(v(1,1,0,0,0, 5,1,0,0,0,0, 1,0,0, 5,1));
    tv.push_back(v(1,1,0,0,0, 5,1,1,0,0,0, 1,0,0, 5,1));
    tv.push_back(v(1,1,0,0,0, 5,1,0,1,0,0, 1,0,1, 5,1));
    // CSR fires at T+5, stalls two cycles
    tv.push_back(v(1,0,1,0,0, 0,0,0,0,0,0, 0,1,0, 5,0));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 5,3));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 5,3));
    // ertn -> DRAIN, stray done ignored, flush releases
    tv.push_back(v(1,0,0,1,0, 0,0,0,0,0,0, 0,1,0, 5,0));
    tv.push_back(v(0,0,0,0,0, 0,0,0,1,0,0, 1,0,0, 5,4));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 5,4));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,1, 1,0,0, 5,4));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 5,0));
    // LSU rd=9, flush at T+2, done at T+6
    tv.push_back(v(1,1,0,0,0, 9,1,0,0,0,0, 0,1,0, 5,0));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 9,1));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,1, 1,0,0, 9,1));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 9,2));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 9,2));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 9,2));
    tv.push_back(v(0,0,0,0,0, 0,0,0,1,0,0, 1,0,0, 9,2));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 9,0));
    // LSU rd=3, flush and done together at T+2
    tv.push_back(v(1,1,0,0,0, 3,1,0,0,0,0, 0,1,0, 9,0));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 3,1));
    tv.push_back(v(0,0,0,0,0, 0,0,0,1,0,1, 1,0,1, 3,1));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 3,0));
    // LSU completes with exception: no writeback
    tv.push_back(v(1,1,0,0,0, 4,1,0,0,0,0, 0,1,0, 3,0));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 4,1));
    tv.push_back(v(0,0,0,0,0, 0,0,0,1,1,0, 1,0,0, 4,1));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 4,0));
    // rd=0 and wen=0: no writeback
    tv.push_back(v(1,1,0,0,0, 0,1,0,0,0,0, 0,1,0, 4,0));
    tv.push_back(v(0,0,0,0,0, 0,0,0,1,0,0, 1,0,0, 0,1));
    tv.push_back(v(1,1,0,0,0, 6,0,0,0,0,0, 0,1,0, 0,0));
    tv.push_back(v(0,0,0,0,0, 0,0,0,1,0,0, 1,0,0, 6,1));
    // exc+lsu -> DRAIN, rd not latched, done ignored, flush at T+7
    tv.push_back(v(1,1,0,0,1, 7,1,0,0,0,0, 0,1,0, 6,0));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 6,4));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 6,4));
    tv.push_back(v(0,0,0,0,0, 0,0,0,1,0,0, 1,0,0, 6,4));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 6,4));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 6,4));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 6,4));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,1, 1,0,0, 6,4));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 6,0));
    // lsu beats csr
    tv.push_back(v(1,1,1,0,0, 2,1,0,0,0,0, 0,1,0, 6,0));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 1,0,0, 2,1));
    tv.push_back(v(0,0,0,0,0, 0,0,0,1,0,0, 1,0,1, 2,1));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 2,0));

    // reset state, with exu_stall passing straight through
    est = 1;
    #1;
    chk("rst_stall", a_stall, 1);
    chk("rst_fire", a_fire, 0);
    chk("rst_wb", a_wb, 0);
    chk("rst_llrd", a_rd, 0);
    chk("rst_state", a_st, 0);
    chk("rst_werr", a_werr, 0);
    est = 0;
    @(negedge clk);
    resetn = 1;

    foreach (tv[i]) begin
      @(negedge clk);
      {vld, lsu, csr, ertn, exc} = {tv[i].vld, tv[i].lsu, tv[i].csr, tv[i].ertn, tv[i].exc};
      {rd, wen, est, done, lexc, fl} = {tv[i].rd, tv[i].wen, tv[i].est, tv[i].done, tv[i].lexc, tv[i].fl};
      #1;
      chk($sformatf("v%0d_stall", i), a_stall, tv[i].e_stall);
      chk($sformatf("v%0d_fire", i), a_fire, tv[i].e_fire);
      chk($sformatf("v%0d_wb", i), a_wb, tv[i].e_wb);
      chk($sformatf("v%0d_llrd", i), a_rd, tv[i].e_rd);
      chk($sformatf("v%0d_state", i), a_st, tv[i].e_st);
    end

    // asynchronous reset in the middle of LSU_BUSY, mid-cycle
    do_reset();
    @(negedge clk);
    vld = 1; lsu = 1; rd = 5; wen = 1;
    @(negedge clk);
    clr();
    @(negedge clk);
    @(negedge clk);
    done = 1;
    #1;
    chk("ar_pre_wb", a_wb, 1);
    #1;
    resetn = 0;
    #1;
    chk("ar_state", a_st, 0);
    chk("ar_stall", a_stall, 0);
    chk("ar_wb", a_wb, 0);
    chk("ar_llrd", a_rd, 0);
    @(negedge clk);
    clr();
    resetn = 1;

    // CSR_LAT=1 (dut_b) vs CSR_LAT=2 (dut_a)
    @(negedge clk);
    vld = 1; csr = 1;
    #1;
    chk("csr_fire_a", a_fire, 1);
    chk("csr_fire_b", b_fire, 1);
    @(negedge clk);
    clr();
    #1;
    chk("csr1_stall_b", b_stall, 1);
    chk("csr1_stall_a", a_stall, 1);
    @(negedge clk);
    vld = 1;
    #1;
    chk("csr2_stall_b", b_stall, 0);
    chk("csr2_fire_b", b_fire, 1);
    chk("csr2_stall_a", a_stall, 1);
    @(negedge clk);
    #1;
    chk("csr3_fire_a", a_fire, 1);
    chk("csr3_state_b", b_st, 0);

    // watchdog on dut_b (WDOG_W=4): LSU never completes
    do_reset();
    @(negedge clk);
    vld = 1; lsu = 1; rd = 8; wen = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      clr();
      #1;
      chk($sformatf("wd%0d_b", k), b_werr, k >= 16);
    end
    chk("wd_a_quiet", a_werr, 0);
    @(negedge clk);
    done = 1;
    #1;
    chk("wd_done_wb", b_wb, 1);
    @(negedge clk);
    clr();
    #1;
    chk("wd_after_state", b_st, 0);
    chk("wd_sticky", b_werr, 1);
    resetn = 0;
    #1;
    chk("wd_rst_clear", b_werr, 0);
    @(negedge clk);
    resetn = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/c7bifu_issue_ctl.md
Name: c7bifu_issue_ctl

Overview:
- Issue sequencer between the decode stage and the EXU. Generates the decode/fetch stall and serialises long-latency and side-effecting instructions.
- LSU ops hold the pipe until the LSU completes. CSR ops hold it for a fixed latency. Exception and ertn ops hold it until the EXU flushes.
- Latches the destination register of the outstanding LSU op so the EXU control logic can write it back after the main pipeline has moved on.

Parameters:
CSR_LAT, 2, cycles of stall after a CSR op fires (>=1)
WDOG_W, 8, width of LSU watchdog counter; timeout at all-ones

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_vld_d  in  1  raw decode-stage valid, NOT stall-gated (avoids comb loop)
dec_lsu_d  in  1  decode class bit: LSU op (ungated)
dec_csr_d  in  1  decode class bit: CSR/TLB/cache op (ungated)
dec_ertn_d  in  1  decode class bit: ertn
dec_exc_d  in  1  decode-detected exception (syscall/break/ine)
dec_rd_d  in  5  destination register
dec_wen_d  in  1  GR write enable
exu_stall  in  1  external stall request from EXU
exu_lsu_done  in  1  LSU completion pulse
exu_lsu_exc  in  1  LSU completed with exception (qualifies exu_lsu_done)
flush  in  1  pipeline flush from EXU
stall  out  1  stall to decode and fetch
issue_fire_d  out  1  instruction accepted into EXU this cycle
ll_rd  out  5  latched rd of outstanding LSU op
ll_wb_vld  out  1  one-cycle pulse: write ll_rd with load data
state_o  out  3  current FSM state (debug)
wdog_err  out  1  sticky: LSU exceeded watchdog

Behaviour:
- Asynchronous reset (resetn low): state=IDLE; counters=0; ll_rd=0; wdog_err=0. All outputs 0 except stall = exu_stall.
- fire = inst_vld_d & ~stall & ~flush; issue_fire_d = fire.
- stall = exu_stall | (state != IDLE). Combinational from registered state; the decoder never sees a cycle-0 stall from its own op.
- Class priority on fire: exc > ertn > lsu > csr. Only the highest class is acted on.

States:
- IDLE: fire&dec_exc_d or fire&dec_ertn_d -> DRAIN. fire&dec_lsu_d -> LSU_BUSY; latch ll_rd=dec_rd_d, wen_q=dec_wen_d, wdog=0. fire&dec_csr_d -> CSR_BUSY with cnt=CSR_LAT-1. Otherwise stay.
- LSU_BUSY:
  - exu_lsu_done -> IDLE; ll_wb_vld = wen_q & ~exu_lsu_exc & (ll_rd != 0).
  - flush without done -> LSU_KILL.
  - flush with done in the same cycle: completion wins; writeback per the rule above -> IDLE.
  - wdog increments each cycle, saturating at all-ones; reaching all-ones sets wdog_err (cleared only by reset).
- LSU_KILL: stall held, wdog continues. exu_lsu_done -> IDLE with ll_wb_vld=0.
- CSR_BUSY: cnt decrements; cnt==0 -> IDLE. flush -> IDLE immediately.
- DRAIN: stall held until flush -> IDLE. exu_lsu_done is ignored.
- Stray exu_lsu_done outside LSU_BUSY/LSU_KILL is ignored.
- Next instruction may fire in the first cycle the FSM is back in IDLE, i.e. one cycle after the terminating event.
- flush in IDLE: no fire; state stays IDLE.
- exu_stall while a non-IDLE state is active: no effect on transitions.
- ll_rd holds its value until the next LSU fire.

Test Plan:
- Reset mid-LSU_BUSY (resetn low at cycle 3) -> state=IDLE, stall=0, ll_wb_vld=0 immediately, asynchronously.
- LSU load rd=5, wen=1 fires at T; exu_lsu_done at T+4 -> stall=1 for T+1..T+4; ll_wb_vld=1, ll_rd=5 at T+4; next instruction fire at T+5.
- LSU fires; flush at T+2; done at T+6 -> state LSU_KILL T+3..T+6; ll_wb_vld never asserted; IDLE at T+7. Same LSU with flush and done together at T+2 -> ll_wb_vld=1, IDLE at T+3.
- CSR op fires with CSR_LAT=2 -> stall=1 exactly at T+1 and T+2, fire possible at T+3; with CSR_LAT=1 -> stall only at T+1.
- Op with dec_exc_d=1 and dec_lsu_d=1 fires -> DRAIN, not LSU_BUSY; stall held until flush at T+7; IDLE at T+8. A done pulse during DRAIN is ignored.
- WDOG_W=4; LSU never completes -> wdog_err=1 on the cycle wdog reaches 15; remains set after a later done, and is cleared only by reset.
